// File: rtl/fp32_to_bf16_pipe.sv
// Multi-lane FP32 -> BF16 converter with two register stages and valid/ready flow control.
// S1 classifies each operand and pre-computes the rounded magnitude; S2 forms the result and flags.
module fp32_to_bf16_pipe #(
   parameter int LANES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*32-1:0]   in_data,
   input  logic [2:0]            in_rm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*16-1:0]   out_data,
   output logic [LANES*4-1:0]    out_flags,
   output logic [3:0]            fflags,
   input  logic                  fflags_clr
);

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   logic                 s1_valid_reg;
   logic                 s2_valid_reg;
   logic [2:0]           s1_rm_reg;
   logic                 s2_advance;
   logic                 in_fire;
   logic                 s1_fire;
   logic                 out_fire;
   logic [2:0]           rm_eff;
   logic [LANES*16-1:0]  out_data_reg;
   logic [LANES*16-1:0]  out_data_next;
   logic [LANES*4-1:0]   out_flags_reg;
   logic [LANES*4-1:0]   out_flags_next;
   logic [3:0]           fflags_reg;
   logic [3:0]           lane_flags_or;

   assign s2_advance = !s2_valid_reg || out_ready;
   assign in_ready   = !s1_valid_reg || s2_advance;
   assign in_fire    = in_valid && in_ready;
   assign s1_fire    = s1_valid_reg && s2_advance;
   assign out_fire   = s2_valid_reg && out_ready;
   // Reserved rounding codes fall back to round-to-nearest-even.
   assign rm_eff     = (in_rm > RM_RMM) ? RM_RNE : in_rm;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic        sgn;
         logic [7:0]  ex;
         logic [22:0] mn;
         logic        guard_bit;
         logic        sticky_bit;
         logic        nx;
         logic        inc;
         logic [14:0] sum;
         logic        s1_sign_reg;
         logic        s1_nx_reg;
         logic        s1_nan_reg;
         logic        s1_snan_reg;
         logic        s1_inf_reg;
         logic        s1_zero_reg;
         logic        s1_sub_reg;
         logic [14:0] s1_sum_reg;
         logic [15:0] res_next;
         logic [3:0]  flg_next;

         assign sgn        = in_data[32*gi+31];
         assign ex         = in_data[32*gi+23 +: 8];
         assign mn         = in_data[32*gi +: 23];
         assign guard_bit  = mn[15];
         assign sticky_bit = |mn[14:0];
         assign nx         = guard_bit || sticky_bit;

         always_comb begin
            inc = 1'b0;
            case (rm_eff)
               RM_RTZ:  inc = 1'b0;
               RM_RDN:  inc = sgn && nx;
               RM_RUP:  inc = !sgn && nx;
               RM_RMM:  inc = guard_bit;
               default: inc = guard_bit && (sticky_bit || mn[16]);
            endcase
         end

         // Mantissa carry ripples into the exponent; only meaningful for normal inputs.
         assign sum = {ex, mn[22:16]} + {14'd0, inc};

         always_ff @(posedge clk) begin
            if (reset) begin
               s1_sign_reg <= 1'b0;
               s1_nx_reg   <= 1'b0;
               s1_nan_reg  <= 1'b0;
               s1_snan_reg <= 1'b0;
               s1_inf_reg  <= 1'b0;
               s1_zero_reg <= 1'b0;
               s1_sub_reg  <= 1'b0;
               s1_sum_reg  <= '0;
            end else if (in_fire) begin
               s1_sign_reg <= sgn;
               s1_nx_reg   <= nx;
               s1_nan_reg  <= (ex == 8'hFF) && (mn != 23'd0);
               s1_snan_reg <= (ex == 8'hFF) && (mn != 23'd0) && !mn[22];
               s1_inf_reg  <= (ex == 8'hFF) && (mn == 23'd0);
               s1_zero_reg <= (ex == 8'h00) && (mn == 23'd0);
               s1_sub_reg  <= (ex == 8'h00) && (mn != 23'd0);
               s1_sum_reg  <= sum;
            end
         end

         always_comb begin
            res_next = {s1_sign_reg, s1_sum_reg};
            flg_next = 4'b0000;
            if (s1_nan_reg) begin
               res_next = 16'h7FC0;
               flg_next = {s1_snan_reg, 3'b000};
            end else if (s1_inf_reg) begin
               res_next = {s1_sign_reg, 8'hFF, 7'h00};
            end else if (s1_zero_reg) begin
               res_next = {s1_sign_reg, 15'h0000};
            end else if (s1_sub_reg) begin
               res_next = {s1_sign_reg, 15'h0000};
               flg_next = 4'b0011;
            end else if (s1_sum_reg[14:7] == 8'hFF) begin
               // Overflow saturates to max-finite unless the mode rounds toward infinity.
               flg_next = 4'b0101;
               case (s1_rm_reg)
                  RM_RTZ:  res_next = {s1_sign_reg, 15'h7F7F};
                  RM_RDN:  res_next = s1_sign_reg ? 16'hFF80 : 16'h7F7F;
                  RM_RUP:  res_next = s1_sign_reg ? 16'hFF7F : 16'h7F80;
                  default: res_next = {s1_sign_reg, 8'hFF, 7'h00};
               endcase
            end else begin
               flg_next = {3'b000, s1_nx_reg};
            end
         end

         assign out_data_next[16*gi +: 16] = res_next;
         assign out_flags_next[4*gi +: 4]  = flg_next;
      end
   endgenerate

   always_comb begin
      lane_flags_or = 4'b0000;
      for (int i = 0; i < LANES; i++) begin
         lane_flags_or = lane_flags_or | out_flags_reg[4*i +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         s1_rm_reg     <= RM_RNE;
         out_data_reg  <= '0;
         out_flags_reg <= '0;
         fflags_reg    <= 4'b0000;
      end else begin
         if (in_ready) begin
            s1_valid_reg <= in_valid;
         end
         if (in_fire) begin
            s1_rm_reg <= rm_eff;
         end
         if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
         end
         if (s1_fire) begin
            out_data_reg  <= out_data_next;
            out_flags_reg <= out_flags_next;
         end
         if (fflags_clr) begin
            fflags_reg <= out_fire ? lane_flags_or : 4'b0000;
         end else if (out_fire) begin
            fflags_reg <= fflags_reg | lane_flags_or;
         end
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_data  = out_data_reg;
   assign out_flags = out_flags_reg;
   assign fflags    = fflags_reg;

endmodule

// File: tb/tb_fp32_to_bf16_pipe.sv
// Randomized bench for fp32_to_bf16_pipe: arithmetic rounding model, scoreboard queue,
// sticky-flag model, plus directed backpressure and reset-in-flight scenarios.
module tb_fp32_to_bf16_pipe;
   localparam int LANES = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*32-1:0]  in_data;
   logic [2:0]           in_rm;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANES*16-1:0]  out_data;
   logic [LANES*4-1:0]   out_flags;
   logic [3:0]           fflags;
   logic                 fflags_clr;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [LANES*16-1:0] d;
      logic [LANES*4-1:0]  f;
   } exp_t;
   exp_t exp_q[$];

   logic [3:0]          sticky_model = 4'h0;
   logic                prev_stall = 1'b0;
   logic [LANES*16-1:0] prev_d;
   logic [LANES*4-1:0]  prev_f;

   fp32_to_bf16_pipe #(.LANES(LANES)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_rm      (in_rm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_flags  (out_flags),
      .fflags     (fflags),
      .fflags_clr (fflags_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: truncate to the upper 16 bits and round using the discarded half-word.
   function automatic void model(input logic [31:0] x, input logic [2:0] rm,
                                 output logic [15:0] r, output logic [3:0] f);
      logic        s;
      int unsigned e, m, t, rem, rmi;
      bit          up, to_inf;
      s   = x[31];
      e   = x[30:23];
      m   = x[22:0];
      t   = x[30:16];
      rem = x[15:0];
      rmi = (rm > 3'd4) ? 0 : rm;
      f   = 4'h0;
      r   = 16'h0;
      if (e == 255 && m != 0) begin
         r = 16'h7FC0;
         f[3] = (m < 32'h400000);
      end else if (e == 255) begin
         r = {s, 15'h7F80};
      end else if (e == 0) begin
         r = {s, 15'h0000};
         if (m != 0) f = 4'b0011;
      end else begin
         case (rmi)
            0:       up = (rem > 32768) || (rem == 32768 && (t % 2) == 1);
            1:       up = 1'b0;
            2:       up = s && (rem != 0);
            3:       up = !s && (rem != 0);
            default: up = (rem >= 32768);
         endcase
         t = t + (up ? 1 : 0);
         f[0] = (rem != 0);
         if (t >= 32'h7F80) begin
            f = 4'b0101;
            to_inf = (rmi == 0) || (rmi == 4) || (rmi == 3 && !s) || (rmi == 2 && s);
            r = to_inf ? {s, 15'h7F80} : {s, 15'h7F7F};
         end else begin
            r = {s, t[14:0]};
         end
      end
   endfunction

   function automatic logic [31:0] rand_fp32();
      logic [7:0]  e;
      logic [22:0] m;
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 7))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         2:       e = 8'hFE;
         default: e = 8'($urandom_range(1, 254));
      endcase
      case ($urandom_range(0, 3))
         0:       m = w[22:0];
         1:       m = {w[6:0], 16'h8000};
         2:       m = {7'h7F, w[15:0]};
         default: m = ($urandom_range(0, 1) == 0) ? 23'd0 : {w[6:0], 16'h0000};
      endcase
      return {w[31], e, m};
   endfunction

   function automatic logic [LANES*32-1:0] rand_vec();
      logic [LANES*32-1:0] v;
      for (int i = 0; i < LANES; i++) v[32*i +: 32] = rand_fp32();
      return v;
   endfunction

   // Monitor: scoreboard, hold-stability and sticky-flag checks, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t        ev;
      exp_t        got;
      logic [3:0]  hs_flags;
      logic [15:0] r;
      logic [3:0]  f;
      if (reset) begin
         exp_q.delete();
         sticky_model = 4'h0;
         prev_stall   = 1'b0;
      end else begin
         chk("fflags", {60'd0, fflags}, {60'd0, sticky_model});
         if (prev_stall) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {{(64-LANES*16){1'b0}}, out_data}, {{(64-LANES*16){1'b0}}, prev_d});
            chk("hold_flags", {{(64-LANES*4){1'b0}}, out_flags}, {{(64-LANES*4){1'b0}}, prev_f});
         end
         hs_flags = 4'h0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("stale_output", {63'd0, out_valid}, 64'd0);
            end else begin
               ev = exp_q.pop_front();
               got.d = out_data;
               got.f = out_flags;
               for (int i = 0; i < LANES; i++) begin
                  chk($sformatf("lane%0d_data", i), {48'd0, got.d[16*i +: 16]}, {48'd0, ev.d[16*i +: 16]});
                  chk($sformatf("lane%0d_flags", i), {60'd0, got.f[4*i +: 4]}, {60'd0, ev.f[4*i +: 4]});
                  hs_flags = hs_flags | ev.f[4*i +: 4];
               end
            end
         end
         if (in_valid && in_ready) begin
            for (int i = 0; i < LANES; i++) begin
               model(in_data[32*i +: 32], in_rm, r, f);
               ev.d[16*i +: 16] = r;
               ev.f[4*i +: 4]   = f;
            end
            exp_q.push_back(ev);
         end
         sticky_model = fflags_clr ? hs_flags : (sticky_model | hs_flags);
         prev_stall   = out_valid && !out_ready;
         prev_d       = out_data;
         prev_f       = out_flags;
      end
   end

   logic [31:0] pin_x  [14] = '{32'h3F808000, 32'h3F818000, 32'h7F7FFFFF, 32'h7F7FFFFF,
                                32'hFF7FFFFF, 32'h7F800001, 32'h7FC00000, 32'h00000001,
                                32'h3F80FFFF, 32'hBF80FFFF, 32'h7F7FFFFF, 32'hFF7FFFFF,
                                32'h3F808000, 32'hFF800000};
   logic [2:0]  pin_rm [14] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0,
                                3'd2, 3'd2, 3'd5, 3'd2, 3'd4, 3'd0};
   logic [15:0] pin_r  [14] = '{16'h3F80, 16'h3F82, 16'h7F80, 16'h7F7F, 16'hFF7F, 16'h7FC0, 16'h7FC0,
                                16'h0000, 16'h3F80, 16'hBF81, 16'h7F80, 16'hFF80, 16'h3F81, 16'hFF80};
   logic [3:0]  pin_f  [14] = '{4'h1, 4'h1, 4'h5, 4'h1, 4'h1, 4'h8, 4'h0,
                                4'h3, 4'h1, 4'h1, 4'h5, 4'h5, 4'h1, 4'h0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0]         r;
      logic [3:0]          f;
      logic [LANES*32-1:0] bp_vec [4];
      int                  acc;
      int                  n;

      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_rm = 3'd0;
      out_ready = 1'b0; fflags_clr = 1'b0;
      repeat (3) step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {{(64-LANES*16){1'b0}}, out_data}, 64'd0);
      chk("rst_out_flags", {{(64-LANES*4){1'b0}}, out_flags}, 64'd0);
      chk("rst_fflags", {60'd0, fflags}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      reset = 1'b0;

      // Hand-computed points that pin the reference model.
      for (int i = 0; i < 14; i++) begin
         model(pin_x[i], pin_rm[i], r, f);
         chk($sformatf("pin%0d_res", i), {48'd0, r}, {48'd0, pin_r[i]});
         chk($sformatf("pin%0d_flg", i), {60'd0, f}, {60'd0, pin_f[i]});
      end

      // Directed operands through the DUT, each in lane 0 with random neighbours.
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1;
         in_data  = rand_vec();
         in_data[31:0] = pin_x[i];
         in_rm    = pin_rm[i];
         step();
      end
      drain();

      // Randomized traffic with random backpressure and sticky clears.
      for (int c = 0; c < 1500; c++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_data    = rand_vec();
         in_rm      = 3'($urandom_range(0, 7));
         out_ready  = ($urandom_range(0, 3) != 0);
         fflags_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      fflags_clr = 1'b0;
      drain();

      // Backpressure: 4 vectors offered against a stalled output.
      for (int i = 0; i < 4; i++) bp_vec[i] = rand_vec();
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_data  = bp_vec[acc];
         in_rm    = 3'(c % 5);
         @(negedge clk);
         if (in_ready) acc++;
         step();
      end
      chk("bp_accepted", 64'(acc), 64'd2);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      n = 0;
      while (acc < 4 && n < 20) begin
         in_valid = 1'b1;
         in_data  = bp_vec[acc];
         @(negedge clk);
         if (in_ready) acc++;
         step();
         n++;
      end
      chk("bp_all_accepted", 64'(acc), 64'd4);
      drain();

      // Reset with two vectors in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = rand_vec();
      step();
      in_data   = rand_vec();
      step();
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      chk("rstfly_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rstfly_fflags", {60'd0, fflags}, 64'd0);
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (10) step();
      chk("rstfly_idle_valid", {63'd0, out_valid}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
